// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential multiply/divide controllers.
// Provides the controller state encoding, the default operand width, and abs/negate helpers.
package mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIX,
    ST_DONE
  } mult_state_e;

  localparam int unsigned MULT_WIDTH = 32;

  // Helpers operate on a wide container; callers zero-extend in and truncate out.
  localparam int unsigned MULT_MAX_W = 128;

  function automatic logic [MULT_MAX_W-1:0] mult_negate(input logic [MULT_MAX_W-1:0] x);
    return '0 - x;
  endfunction

  function automatic logic [MULT_MAX_W-1:0] mult_abs(input logic [MULT_MAX_W-1:0] x,
                                                     input int unsigned w,
                                                     input logic is_signed);
    logic [MULT_MAX_W-1:0] sign_sh;
    sign_sh = x >> (w - 1);
    return (is_signed && sign_sh[0]) ? mult_negate(x) : x;
  endfunction

endpackage

// File: rtl/mult_add_shift.sv
// Single combinational shift-add step: conditionally add mcand into hi when lo[0] is set,
// then shift {carry, hi, lo} right by one.
module mult_add_shift
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = MULT_WIDTH
) (
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] mcand,
  output logic [WIDTH-1:0] hi_nxt,
  output logic [WIDTH-1:0] lo_nxt
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum = {1'b0, hi};
    if (lo[0]) begin
      sum = sum + {1'b0, mcand};
    end
    hi_nxt = sum[WIDTH:1];
    lo_nxt = {sum[0], lo[WIDTH-1:1]};
  end

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequential shift-add multiplier controller (signed/unsigned, 2*WIDTH-bit product, done pulse).
// Optional MULT_EARLY_EXIT_EN: finish RUN early once the remaining multiplier bits are all zero.
module mult_seq_ctrl
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = MULT_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               signed_op,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic               ovf
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  mult_state_e        state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   mcand_reg;
  logic [2*WIDTH-1:0] prod;
  logic               neg_res;
  logic               op_signed;

  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH-1:0]   step_hi;
  logic [WIDTH-1:0]   step_lo;
  logic [2*WIDTH-1:0] fixed;
  logic               ovf_nxt;

  mult_add_shift #(
    .WIDTH(WIDTH)
  ) u_step (
    .hi    (prod[2*WIDTH-1:WIDTH]),
    .lo    (prod[WIDTH-1:0]),
    .mcand (mcand_reg),
    .hi_nxt(step_hi),
    .lo_nxt(step_lo)
  );

  always_comb begin
    abs_a = WIDTH'(mult_abs(MULT_MAX_W'(multiplicand), WIDTH, signed_op));
    abs_b = WIDTH'(mult_abs(MULT_MAX_W'(multiplier), WIDTH, signed_op));
    fixed = neg_res ? (2*WIDTH)'(mult_negate(MULT_MAX_W'(prod))) : prod;
    if (op_signed) begin
      ovf_nxt = fixed[2*WIDTH-1:WIDTH] != {WIDTH{fixed[WIDTH-1]}};
    end else begin
      ovf_nxt = fixed[2*WIDTH-1:WIDTH] != '0;
    end
  end

`ifdef MULT_EARLY_EXIT_EN
  localparam logic [WIDTH-1:0] ONES = '1;
  logic rem_zero;

  // Bits [cnt-1:0] of lo are the multiplier bits not yet consumed; cnt==0 yields an empty mask.
  always_comb begin
    rem_zero = (prod[WIDTH-1:0] & ~(ONES << cnt)) == '0;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      mcand_reg <= '0;
      prod      <= '0;
      neg_res   <= 1'b0;
      op_signed <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      product   <= '0;
      ovf       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            neg_res   <= signed_op & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1])
                         & (|multiplicand) & (|multiplier);
            op_signed <= signed_op;
            mcand_reg <= abs_a;
            prod      <= {{WIDTH{1'b0}}, abs_b};
            cnt       <= CNT_W'(WIDTH);
            busy      <= 1'b1;
            state     <= ST_RUN;
          end
        end
        ST_RUN: begin
`ifdef MULT_EARLY_EXIT_EN
          if (rem_zero) begin
            prod  <= prod >> cnt;
            cnt   <= '0;
            state <= ST_FIX;
          end else begin
            prod <= {step_hi, step_lo};
            cnt  <= cnt - CNT_W'(1);
          end
`else
          if (cnt == '0) begin
            state <= ST_FIX;
          end else begin
            prod <= {step_hi, step_lo};
            cnt  <= cnt - CNT_W'(1);
          end
`endif
        end
        ST_FIX: begin
          product <= fixed;
          ovf     <= ovf_nxt;
          busy    <= 1'b0;
          done    <= 1'b1;
          state   <= ST_DONE;
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
